// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA pixel pipeline.
package vga_pkg;

  localparam int FB_W        = 160;
  localparam int FB_H        = 120;
  localparam int SCALE_SHIFT = 2;

  localparam int COORD_W   = 10;
  localparam int ADDR_W    = 15;
  localparam int COLOR_W   = 4;
  localparam int IDX_W     = 4;
  localparam int RGB_W     = 3 * COLOR_W;
  localparam int PAL_DEPTH = 1 << IDX_W;

  // Power-on palette: a greyscale ramp, entry n = {n,n,n}.
  function automatic logic [RGB_W-1:0] pal_default(input logic [IDX_W-1:0] n);
    return {n, n, n};
  endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read bus and palette write port of the pixel pipeline.
interface vga_pixel_pipe_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0] fb_addr;
  logic [IDX_W-1:0]  fb_data;
  logic              pal_we;
  logic [IDX_W-1:0]  pal_addr;
  logic [RGB_W-1:0]  pal_data;

  // Host side: owns the framebuffer memory and the palette writer.
  modport master (
    input  fb_addr,
    output fb_data, pal_we, pal_addr, pal_data
  );

  // Pipeline side.
  modport slave (
    output fb_addr,
    input  fb_data, pal_we, pal_addr, pal_data
  );

endinterface

// File: rtl/vga_palette.sv
// 16 x 12-bit colour palette: synchronous write, combinational read,
// asynchronous reset to a greyscale ramp. A read on the same edge as a
// write to the same entry sees the old value.
module vga_palette
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [RGB_W-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [RGB_W-1:0] o_rdata
);

  logic [RGB_W-1:0] pal_q [PAL_DEPTH];

  // Palette storage: ramp on reset, otherwise write whenever enabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        pal_q[i] <= pal_default(IDX_W'(i));
      end
    end else if (i_we) begin
      pal_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = pal_q[i_raddr];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Three-stage VGA pixel pipeline: framebuffer address -> palette index ->
// palette colour, with syncs delayed to stay aligned with the colour.
// All stages advance only on pixel-strobe cycles.
module vga_pixel_pipe
  import vga_pkg::*;
#(
  parameter int FB_W        = vga_pkg::FB_W,
  parameter int FB_H        = vga_pkg::FB_H,
  parameter int SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_clk,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_active,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  vga_pixel_pipe_if.slave    bus,
  output logic [COLOR_W-1:0] o_vga_r,
  output logic [COLOR_W-1:0] o_vga_g,
  output logic [COLOR_W-1:0] o_vga_b,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_frame_start
);

  // Address arithmetic is done modulo 2^ADDR_W, so out-of-range
  // coordinates simply wrap.
  logic [ADDR_W-1:0] row_w, col_w, addr_calc;
  assign row_w = ADDR_W'(i_y >> SCALE_SHIFT);
  assign col_w = ADDR_W'(i_x >> SCALE_SHIFT);

  if (FB_W == 160) begin : g_mul160
    assign addr_calc = (row_w << 7) + (row_w << 5) + col_w;
  end else begin : g_mul_generic
    assign addr_calc = row_w * ADDR_W'(FB_W) + col_w;
  end

  // Stage registers
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
  logic [IDX_W-1:0]  idx2_q, idx2_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, act2_q, act2_d;
  logic [RGB_W-1:0]  rgb3_q, rgb3_d;
  logic              hs3_q, hs3_d, vs3_q, vs3_d, act3_q, act3_d;
  logic              fs_q, fs_d;
  logic [RGB_W-1:0]  pal_rdata;

  vga_palette u_palette (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (bus.pal_we),
    .i_waddr (bus.pal_addr),
    .i_wdata (bus.pal_data),
    .i_raddr (idx2_q),
    .o_rdata (pal_rdata)
  );

  // Next-state: hold everything unless this cycle carries a pixel strobe.
  always_comb begin
    addr_d = addr_q;  hs1_d = hs1_q;  vs1_d = vs1_q;  act1_d = act1_q;
    idx2_d = idx2_q;  hs2_d = hs2_q;  vs2_d = vs2_q;  act2_d = act2_q;
    rgb3_d = rgb3_q;  hs3_d = hs3_q;  vs3_d = vs3_q;  act3_d = act3_q;
    if (i_pix_clk) begin
      addr_d = addr_calc;    hs1_d = i_hsync; vs1_d = i_vsync; act1_d = i_active;
      idx2_d = bus.fb_data;  hs2_d = hs1_q;   vs2_d = vs1_q;   act2_d = act1_q;
      rgb3_d = pal_rdata;    hs3_d = hs2_q;   vs3_d = vs2_q;   act3_d = act2_q;
    end
    // Pulse on the same edge that drives the output vsync from high to low.
    fs_d = i_pix_clk & vs3_q & ~vs2_q;
  end

  // Stage state; syncs reset to their inactive (high) level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q <= '0;   hs1_q <= 1'b1; vs1_q <= 1'b1; act1_q <= 1'b0;
      idx2_q <= '0;   hs2_q <= 1'b1; vs2_q <= 1'b1; act2_q <= 1'b0;
      rgb3_q <= '0;   hs3_q <= 1'b1; vs3_q <= 1'b1; act3_q <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      addr_q <= addr_d; hs1_q <= hs1_d; vs1_q <= vs1_d; act1_q <= act1_d;
      idx2_q <= idx2_d; hs2_q <= hs2_d; vs2_q <= vs2_d; act2_q <= act2_d;
      rgb3_q <= rgb3_d; hs3_q <= hs3_d; vs3_q <= vs3_d; act3_q <= act3_d;
      fs_q   <= fs_d;
    end
  end

  // Visible pixels must map inside the framebuffer; blanked ones may wrap.
  assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (i_pix_clk && i_active) |->
      ((32'(i_y >> SCALE_SHIFT) < FB_H) && (32'(i_x >> SCALE_SHIFT) < FB_W)));

  assign bus.fb_addr = addr_q;
  assign {o_vga_r, o_vga_g, o_vga_b} = act3_q ? rgb3_q : '0;
  assign o_hsync       = hs3_q;
  assign o_vsync       = vs3_q;
  assign o_frame_start = fs_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Self-checking bench for vga_pixel_pipe: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_vga_pixel_pipe;
  import vga_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix, hs, vs, act;
  logic [9:0] x, y;
  logic [3:0] r, g, b;
  logic       ohs, ovs, ofs;

  always #5 clk = ~clk;

  vga_pixel_pipe_if bus ();

  vga_pixel_pipe dut (
    .i_clk (clk), .i_rst_n (rst_n), .i_pix_clk (pix),
    .i_hsync (hs), .i_vsync (vs), .i_active (act), .i_x (x), .i_y (y),
    .bus (bus),
    .o_vga_r (r), .o_vga_g (g), .o_vga_b (b),
    .o_hsync (ohs), .o_vsync (ovs), .o_frame_start (ofs)
  );

  // Framebuffer contents; read data is ready by the next i_clk edge.
  logic [3:0] fbmem [32768];
  assign bus.fb_data = fbmem[bus.fb_addr];

  int fs_seen;
  always @(negedge clk) if (ofs === 1'b1) fs_seen++;

  // ---------------- behavioural model ----------------
  typedef struct { int addr; bit act; bit hs; bit vs; } rec_t;
  rec_t        pq[$];
  logic [11:0] pal_m [16];
  int          exp_addr;
  logic [11:0] exp_rgb;
  bit          exp_hs, exp_vs, exp_fs;
  int          exp_fs_cnt;
  int          checks = 0, failures = 0;

  task automatic model_reset();
    pq.delete();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] n;
      n = 4'(i);
      pal_m[i] = {n, n, n};
    end
    exp_addr = 0; exp_rgb = 12'h0; exp_hs = 1; exp_vs = 1; exp_fs = 0;
  endtask

  // One i_clk cycle: apply inputs, predict outputs, step past the edge.
  task automatic drive(input bit p, input int xi, input int yi, input bit h,
                       input bit v, input bit a, input bit we, input int wa,
                       input logic [11:0] wd);
    rec_t rn, ro;
    logic [11:0] n_rgb;
    bit n_hs, n_vs;
    pix = p; x = 10'(xi); y = 10'(yi); hs = h; vs = v; act = a;
    bus.pal_we = we; bus.pal_addr = 4'(wa); bus.pal_data = wd;
    exp_fs = 0;
    if (p) begin
      rn.addr = ((yi >> 2) * 160 + (xi >> 2)) % 32768;
      rn.act = a; rn.hs = h; rn.vs = v;
      pq.push_back(rn);
      exp_addr = rn.addr;
      if (pq.size() == 3) begin
        ro = pq.pop_front();
        n_rgb = ro.act ? pal_m[fbmem[ro.addr]] : 12'h0;
        n_hs = ro.hs; n_vs = ro.vs;
      end else begin
        n_rgb = 12'h0; n_hs = 1; n_vs = 1;
      end
      exp_fs = exp_vs && !n_vs;
      if (exp_fs) exp_fs_cnt++;
      exp_rgb = n_rgb; exp_hs = n_hs; exp_vs = n_vs;
    end
    if (we) pal_m[wa] = wd;   // lookup above used the pre-write value
    @(posedge clk); #1;
  endtask

  // One pixel period: three idle cycles then the strobe cycle.
  task automatic px(input int xi, input int yi, input bit h, input bit v, input bit a);
    repeat (3) drive(0, xi, yi, h, v, a, 0, 0, 12'h0);
    drive(1, xi, yi, h, v, a, 0, 0, 12'h0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; pix = 0; hs = 1; vs = 1; act = 0; x = 0; y = 0;
    bus.pal_we = 0; bus.pal_addr = 0; bus.pal_data = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.fb_addr !== 15'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", bus.fb_addr); end
    checks++; if ({r, g, b} !== 12'h0) begin failures++; $display("FAIL reset_rgb: got %h expected 000", {r, g, b}); end
    checks++; if (ohs !== 1'b1 || ovs !== 1'b1) begin failures++; $display("FAIL reset_syncs: got hs=%b vs=%b expected 1 1", ohs, ovs); end
    checks++; if (ofs !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b expected 0", ofs); end
    model_reset();
    rst_n = 1;
    for (int s = 0; s < 3; s++) begin
      px($urandom_range(0, 639), $urandom_range(0, 479), 0, 0, 1);
      checks++;
      if ({r, g, b} !== exp_rgb || ohs !== exp_hs || ovs !== exp_vs) begin
        failures++;
        $display("FAIL post_reset_blank[%0d]: got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b",
                 s, {r, g, b}, ohs, ovs, exp_rgb, exp_hs, exp_vs);
      end
    end
  endtask

  task automatic test_directed();
    fbmem[325] = 4'd5;
    drive(0, 0, 0, 1, 1, 0, 1, 5, 12'hF80);
    px(20, 8, 1, 1, 1);
    checks++; if (bus.fb_addr !== 15'd325) begin failures++; $display("FAIL directed_addr: got %0d expected 325", bus.fb_addr); end
    px(0, 0, 1, 1, 0);
    px(0, 0, 1, 1, 0);
    checks++; if ({r, g, b} !== 12'hF80) begin failures++; $display("FAIL directed_rgb: got %h expected f80", {r, g, b}); end
    checks++; if (ohs !== exp_hs || ovs !== exp_vs) begin failures++; $display("FAIL directed_syncs: got %b%b expected %b%b", ohs, ovs, exp_hs, exp_vs); end
  endtask

  task automatic test_blank();
    for (int s = 0; s < 8; s++) begin
      px(20, 8, (s < 6) ? 1'($urandom_range(0, 1)) : 1'b1, (s % 3) != 1, 0);
      if (s >= 2) begin
        checks++; if ({r, g, b} !== 12'h0) begin failures++; $display("FAIL blank_rgb[%0d]: got %h expected 000", s, {r, g, b}); end
      end
      checks++;
      if (ohs !== exp_hs || ovs !== exp_vs) begin
        failures++; $display("FAIL blank_syncs[%0d]: got %b%b expected %b%b", s, ohs, ovs, exp_hs, exp_vs);
      end
    end
  endtask

  task automatic test_hsync_width();
    int low_cnt = 0, first_low = -1;
    for (int s = 0; s < 110; s++) begin
      px($urandom_range(0, 639), $urandom_range(0, 479), (s >= 4 && s < 100) ? 1'b0 : 1'b1, 1, 1);
      if (s >= 2 && ohs === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = s;
      end
      checks++;
      if (ohs !== exp_hs || {r, g, b} !== exp_rgb) begin
        failures++; $display("FAIL hsync_track[%0d]: got hs=%b rgb=%h expected hs=%b rgb=%h", s, ohs, {r, g, b}, exp_hs, exp_rgb);
      end
    end
    checks++; if (low_cnt !== 96) begin failures++; $display("FAIL hsync_width: got %0d expected 96", low_cnt); end
    checks++; if (first_low !== 6) begin failures++; $display("FAIL hsync_delay: got %0d expected 6", first_low); end
  endtask

  task automatic test_corner();
    px(639, 479, 1, 1, 1);
    checks++; if (bus.fb_addr !== 15'd19199) begin failures++; $display("FAIL corner_addr: got %0d expected 19199", bus.fb_addr); end
    px(1023, 1023, 1, 1, 0);
    checks++; if (bus.fb_addr !== 15'd8287) begin failures++; $display("FAIL wrap_addr: got %0d expected 8287", bus.fb_addr); end
    px(0, 0, 1, 1, 0);
    checks++; if ({r, g, b} !== exp_rgb) begin failures++; $display("FAIL corner_rgb: got %h expected %h", {r, g, b}, exp_rgb); end
  endtask

  task automatic test_pal_collision();
    drive(0, 0, 0, 1, 1, 0, 1, 5, 12'hF80);
    px(20, 8, 1, 1, 1);
    px(20, 8, 1, 1, 1);
    repeat (3) drive(0, 0, 0, 1, 1, 0, 0, 0, 12'h0);
    drive(1, 0, 0, 1, 1, 0, 1, 5, 12'h0AB);
    checks++; if ({r, g, b} !== 12'hF80) begin failures++; $display("FAIL collision_old: got %h expected f80", {r, g, b}); end
    px(0, 0, 1, 1, 0);
    checks++; if ({r, g, b} !== 12'h0AB) begin failures++; $display("FAIL collision_new: got %h expected 0ab", {r, g, b}); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 15), 12'($urandom));
      checks++; if (bus.fb_addr !== 15'(exp_addr)) begin failures++; $display("FAIL rand_addr[%0d]: got %0d expected %0d", c, bus.fb_addr, exp_addr); end
      checks++; if ({r, g, b} !== exp_rgb) begin failures++; $display("FAIL rand_rgb[%0d]: got %h expected %h", c, {r, g, b}, exp_rgb); end
      checks++;
      if (ohs !== exp_hs || ovs !== exp_vs || ofs !== exp_fs) begin
        failures++; $display("FAIL rand_sync[%0d]: got hs=%b vs=%b fs=%b expected hs=%b vs=%b fs=%b", c, ohs, ovs, ofs, exp_hs, exp_vs, exp_fs);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 4; s++) px($urandom_range(0, 639), $urandom_range(0, 479), 0, 0, 1);
    rst_n = 0;
    #1;
    checks++; if ({r, g, b} !== 12'h0) begin failures++; $display("FAIL midrst_rgb: got %h expected 000", {r, g, b}); end
    checks++; if (ohs !== 1'b1 || ovs !== 1'b1) begin failures++; $display("FAIL midrst_syncs: got %b%b expected 11", ohs, ovs); end
    checks++; if (bus.fb_addr !== 15'd0 || ofs !== 1'b0) begin failures++; $display("FAIL midrst_addr_fs: got addr=%0d fs=%b expected 0 0", bus.fb_addr, ofs); end
    for (int k = 0; k < 2; k++) begin
      pix = 1; vs = 0;
      @(posedge clk); #1;
      checks++; if (ofs !== 1'b0 || ovs !== 1'b1) begin failures++; $display("FAIL midrst_hold[%0d]: got fs=%b vs=%b expected 0 1", k, ofs, ovs); end
    end
    model_reset();
    fs_seen = 0; exp_fs_cnt = 0;
    rst_n = 1;
    for (int s = 0; s < 60; s++) begin
      px($urandom_range(0, 639), $urandom_range(0, 479), 1, (s % 20) >= 5, 1);
      checks++;
      if ({r, g, b} !== exp_rgb || ovs !== exp_vs || ofs !== exp_fs) begin
        failures++; $display("FAIL after_rst[%0d]: got rgb=%h vs=%b fs=%b expected rgb=%h vs=%b fs=%b", s, {r, g, b}, ovs, ofs, exp_rgb, exp_vs, exp_fs);
      end
    end
    repeat (2) drive(0, 0, 0, 1, 1, 0, 0, 0, 12'h0);
    checks++; if (fs_seen !== exp_fs_cnt) begin failures++; $display("FAIL frame_start_count: got %0d expected %0d", fs_seen, exp_fs_cnt); end
    checks++; if (fs_seen !== 3) begin failures++; $display("FAIL frame_start_total: got %0d expected 3", fs_seen); end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) fbmem[i] = 4'($urandom);
    exp_fs_cnt = 0; fs_seen = 0;
    test_reset();
    test_directed();
    test_blank();
    test_hsync_width();
    test_corner();
    test_pal_collision();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
